// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock, MSB first.
// start/busy/done handshake; divide-by-zero completes in a single edge.
module shift_sub_divider #(
    parameter int BITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [BITS-1:0] dividend,
    input  logic [BITS-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] quotient,
    output logic [BITS-1:0] remainder,
    output logic            div_by_zero
);

    localparam int CW = $clog2(BITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [BITS-1:0] r_dvs;
    logic [BITS-1:0] r_work;
    logic [BITS-1:0] r_rem;

    logic [BITS:0]   w_shifted;
    logic [BITS:0]   w_trial;
    logic            w_borrow;
    logic [BITS-1:0] w_rem_nxt;
    logic [BITS-1:0] w_work_nxt;

    // The trial is one bit wider than the operands; its MSB is the borrow.
    assign w_shifted  = {r_rem, r_work[BITS-1]};
    assign w_trial    = w_shifted - {1'b0, r_dvs};
    assign w_borrow   = w_trial[BITS];
    assign w_rem_nxt  = w_borrow ? w_shifted[BITS-1:0] : w_trial[BITS-1:0];
    assign w_work_nxt = {r_work[BITS-2:0], ~w_borrow};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_dvs       <= '0;
            r_work      <= '0;
            r_rem       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            r_work  <= dividend;
                            r_dvs   <= divisor;
                            r_rem   <= '0;
                            r_cnt   <= CW'(BITS);
                            busy    <= 1'b1;
                            r_state <= RUN;
                        end else begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            r_state     <= DONE;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    r_work <= w_work_nxt;
                    r_rem  <= w_rem_nxt;
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == CW'(1)) begin
                        quotient    <= w_work_nxt;
                        remainder   <= w_rem_nxt;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Directed and exhaustive self-checking bench for shift_sub_divider, BITS=4.
// Covers reset, latency, ignored starts, back-to-back launch and mid-run reset.
module tb_shift_sub_divider;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [3:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    int errors = 0;
    int checks = 0;

    shift_sub_divider #(.BITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] n;
        logic [3:0] d;
        logic [3:0] q;
        logic [3:0] r;
        logic       z;
        int         lat;
        int         bc;
    } vec_t;

    vec_t tv[7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_overlap();
        if (busy && done) check("busy_done_overlap", 1, 0);
    endtask

    // lat = edges after the accepting edge until done is seen; bc = busy cycles.
    task automatic run_op(input logic [3:0] n, input logic [3:0] d,
                          output int lat, output int bc);
        @(negedge clk);
        start    = 1'b1;
        dividend = n;
        divisor  = d;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 4'($urandom);
        divisor  = 4'($urandom);
        lat = 0;
        bc  = 0;
        while (!done && lat < 20) begin
            check_overlap();
            if (busy) bc++;
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 20) check("done_timeout", lat, 4);
    endtask

    int lat, bc, e, d1, d2, nd;

    initial begin
        tv[0] = '{n: 4'd13, d: 4'd3,  q: 4'd4,  r: 4'd1, z: 1'b0, lat: 4, bc: 4};
        tv[1] = '{n: 4'd15, d: 4'd1,  q: 4'd15, r: 4'd0, z: 1'b0, lat: 4, bc: 4};
        tv[2] = '{n: 4'd3,  d: 4'd7,  q: 4'd0,  r: 4'd3, z: 1'b0, lat: 4, bc: 4};
        tv[3] = '{n: 4'd0,  d: 4'd5,  q: 4'd0,  r: 4'd0, z: 1'b0, lat: 4, bc: 4};
        tv[4] = '{n: 4'd15, d: 4'd15, q: 4'd1,  r: 4'd0, z: 1'b0, lat: 4, bc: 4};
        tv[5] = '{n: 4'd5,  d: 4'd0,  q: 4'd15, r: 4'd5, z: 1'b1, lat: 0, bc: 0};
        tv[6] = '{n: 4'd9,  d: 4'd2,  q: 4'd4,  r: 4'd1, z: 1'b0, lat: 4, bc: 4};

        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        #12;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_q", int'(quotient), 0);
        check("rst_r", int'(remainder), 0);
        check("rst_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_done", int'(done), 0);
        end

        for (int i = 0; i < 7; i++) begin
            run_op(tv[i].n, tv[i].d, lat, bc);
            check($sformatf("v%0d_lat", i), lat, tv[i].lat);
            check($sformatf("v%0d_busy_cycles", i), bc, tv[i].bc);
            check($sformatf("v%0d_q", i), int'(quotient), int'(tv[i].q));
            check($sformatf("v%0d_r", i), int'(remainder), int'(tv[i].r));
            check($sformatf("v%0d_dbz", i), int'(div_by_zero), int'(tv[i].z));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_done_width", i), int'(done), 0);
            check($sformatf("v%0d_q_hold", i), int'(quotient), int'(tv[i].q));
        end

        // A start while busy must be ignored, including its operands.
        @(negedge clk);
        start = 1'b1; dividend = 4'd14; divisor = 4'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        e = 0;
        repeat (2) begin @(posedge clk); #1; e++; end
        @(negedge clk);
        start = 1'b1; dividend = 4'd1; divisor = 4'd1;
        @(posedge clk);
        #1;
        e++;
        start = 1'b0; dividend = 4'd7; divisor = 4'd0;
        while (!done && e < 20) begin @(posedge clk); #1; e++; end
        check("ign_lat", e, 4);
        check("ign_q", int'(quotient), 3);
        check("ign_r", int'(remainder), 2);
        check("ign_busy_after", int'(busy), 0);
        repeat (3) begin @(posedge clk); #1; check("ign_no_extra_done", int'(done), 0); end

        // Start held high relaunches in the DONE cycle.
        @(negedge clk);
        start = 1'b1; dividend = 4'd13; divisor = 4'd3;
        @(posedge clk);
        #1;
        d1 = -1; d2 = -1; nd = 0;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            check_overlap();
            if (done) begin
                nd++;
                if (d1 < 0) d1 = k; else d2 = k;
            end
        end
        start = 1'b0;
        check("b2b_first_done", d1, 4);
        check("b2b_second_done", d2, 9);
        check("b2b_done_count", nd, 2);
        check("b2b_q", int'(quotient), 4);
        check("b2b_r", int'(remainder), 1);

        // Asynchronous reset in the middle of a run.
        repeat (2) @(posedge clk);
        @(negedge clk);
        start = 1'b1; dividend = 4'd12; divisor = 4'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", int'(busy), 0);
        check("mid_rst_q", int'(quotient), 0);
        check("mid_rst_r", int'(remainder), 0);
        check("mid_rst_dbz", int'(div_by_zero), 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0;
        repeat (8) begin @(posedge clk); #1; if (done || busy) nd++; end
        check("mid_rst_quiet", nd, 0);
        run_op(4'd12, 4'd5, lat, bc);
        check("mid_rst_redo_lat", lat, 4);
        check("mid_rst_redo_q", int'(quotient), 2);
        check("mid_rst_redo_r", int'(remainder), 2);

        // Exhaustive sweep, back-to-back.
        for (int n = 0; n < 16; n++) begin
            for (int d = 0; d < 16; d++) begin
                run_op(4'(n), 4'(d), lat, bc);
                if (d == 0) begin
                    check($sformatf("sw_z_q_%0d", n), int'(quotient), 15);
                    check($sformatf("sw_z_r_%0d", n), int'(remainder), n);
                    check($sformatf("sw_z_f_%0d", n), int'(div_by_zero), 1);
                end else begin
                    check($sformatf("sw_q_%0d_%0d", n, d), int'(quotient), n / d);
                    check($sformatf("sw_r_%0d_%0d", n, d), int'(remainder), n % d);
                    check($sformatf("sw_trip_%0d_%0d", n, d),
                          int'(quotient) * d + int'(remainder), n);
                    check($sformatf("sw_rltd_%0d_%0d", n, d),
                          int'(int'(remainder) < d), 1);
                    check($sformatf("sw_lat_%0d_%0d", n, d), lat, 4);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
